// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: divides clk by a runtime-programmable ratio N (2..2^W-1)
// with 50% duty for both even and odd N. A new ratio is taken through a
// valid/ready handshake and is applied only at a period boundary, so the
// output never sees a truncated or stretched phase.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | output parked low, cnt held at 0, pending ratio applied now
// RUN      | dividing; ratio changes take effect at period boundaries
// STOPPING | en dropped; finish current period, then park in IDLE
module clk_div_ctrl #(
    parameter int W             = 4,
    parameter int DEFAULT_RATIO = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_ratio,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         clk_out,
    output logic         period_tick,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [W-1:0] DEF_N = W'(DEFAULT_RATIO);
    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] TWO   = W'(2);

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] cur_n, cur_n_nxt;
    logic [W-1:0] pend_n, pend_n_nxt;
    logic [W-1:0] half_nxt;
    logic         pend, pend_nxt;
    logic         err_nxt;
    logic         q, q_nxt;
    logic         q_neg;
    logic         hs;
    logic         boundary;
    logic         apply;

    assign busy        = (state != IDLE);
    assign boundary    = busy && (cnt == (cur_n - ONE));
    assign period_tick = boundary;
    assign cfg_ready   = !pend;
    assign hs          = cfg_valid && !pend;
    // A pending ratio lands at a period boundary, or straight away when idle.
    assign apply       = pend && (!busy || boundary);

    // Odd N: the half-cycle-delayed copy trims the high phase to N/2 cycles.
    assign clk_out = cur_n[0] ? (q & q_neg) : q;

    // Next-state, counter, ratio bookkeeping and output-phase decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cur_n_nxt  = cur_n;
        pend_n_nxt = pend_n;
        pend_nxt   = pend;
        err_nxt    = 1'b0;
        half_nxt   = '0;
        q_nxt      = 1'b0;

        case (state)
            IDLE:     if (en) state_nxt = RUN;
            RUN:      if (!en) state_nxt = STOPPING;
            STOPPING: begin
                if (en)            state_nxt = RUN;
                else if (boundary) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase

        if (!busy || boundary) cnt_nxt = '0;
        else                   cnt_nxt = cnt + ONE;

        if (apply) begin
            cur_n_nxt = pend_n;
            pend_nxt  = 1'b0;
        end

        // Handshake uses the ratio seen this cycle; apply and hs are exclusive
        // because hs requires no ratio pending.
        if (hs) begin
            if (cfg_ratio < TWO) begin
                err_nxt = 1'b1;
            end else begin
                pend_n_nxt = cfg_ratio;
                pend_nxt   = 1'b1;
            end
        end

        // High while cnt < ceil(N/2) of the ratio in force after this edge.
        half_nxt = (cur_n_nxt >> 1) + {{(W-1){1'b0}}, cur_n_nxt[0]};
        q_nxt    = (state_nxt != IDLE) && (cnt_nxt < half_nxt);
    end

    // State, counter and configuration registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_n   <= DEF_N;
            pend_n  <= DEF_N;
            pend    <= 1'b0;
            cfg_err <= 1'b0;
            q       <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_n   <= cur_n_nxt;
            pend_n  <= pend_n_nxt;
            pend    <= pend_nxt;
            cfg_err <= err_nxt;
            q       <= q_nxt;
        end
    end

    // Negedge copy of the phase register, used only for odd ratios.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) q_neg <= 1'b0;
        else      q_neg <= q;
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: directed scenarios plus random traffic, all
// compared against a period-level reference model. The model describes the
// output as a high window of N half-cycles per period, shifted by one
// half-cycle when N is odd.
module tb_clk_div_ctrl;
    localparam int W   = 4;
    localparam int DEF = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_ratio = '0;
    logic         cfg_ready, cfg_err, clk_out, period_tick, busy;

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_ctrl #(.W(W), .DEFAULT_RATIO(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ratio  (cfg_ratio),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .period_tick(period_tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: running/stopping flags, position in period, ratios.
    bit m_run, m_stop, m_pend, m_err;
    int m_pos, m_n, m_pend_n;

    function automatic void model_reset();
        m_run = 0; m_stop = 0; m_pend = 0; m_err = 0;
        m_pos = 0; m_n = DEF; m_pend_n = DEF;
    endfunction

    function automatic bit m_busy();
        return m_run || m_stop;
    endfunction

    function automatic bit m_tick();
        return m_busy() && (m_pos == m_n - 1);
    endfunction

    // Expected clk_out just after a posedge (neg=0) or a negedge (neg=1).
    function automatic bit m_clk(input bit neg);
        int h;
        if (!m_busy()) return 1'b0;
        h = 2 * m_pos + (neg ? 1 : 0);
        if (m_n % 2 == 1) return (h >= 1) && (h <= m_n);
        return h < m_n;
    endfunction

    // Advance the model by one posedge using the inputs currently driven.
    function automatic void model_edge();
        bit tick, hs, was_busy;
        was_busy = m_busy();
        tick     = m_tick();
        hs       = cfg_valid && !m_pend;
        if (m_pend && (!was_busy || tick)) begin
            m_n = m_pend_n;
            m_pend = 0;
        end
        if (!was_busy) begin
            m_pos = 0;
            if (en) m_run = 1;
        end else begin
            m_pos = tick ? 0 : m_pos + 1;
            if (m_run && !en) begin
                m_run = 0; m_stop = 1;
            end else if (m_stop && en) begin
                m_stop = 0; m_run = 1;
            end else if (m_stop && tick) begin
                m_stop = 0;
            end
        end
        m_err = hs && (int'(cfg_ratio) < 2);
        if (hs && int'(cfg_ratio) >= 2) begin
            m_pend = 1;
            m_pend_n = int'(cfg_ratio);
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        model_reset();
        #2;
        n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL reset_clk_out got %b exp 0", clk_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (period_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b exp 0", period_tick); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", cfg_err); end
        half();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b exp 0", busy); end
            n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL idle_clk_out got %b exp 0", clk_out); end
            half();
        end
    endtask

    task automatic test_default_ratio();
        int last_tick, gap;
        last_tick = -1;
        en = 1'b1;
        for (int i = 0; i < 22; i++) begin
            step();
            n_cmp++; if (clk_out !== m_clk(0)) begin n_bad++; $display("FAIL def_clk_pos got %b exp %b cyc %0d", clk_out, m_clk(0), i); end
            n_cmp++; if (period_tick !== m_tick()) begin n_bad++; $display("FAIL def_tick got %b exp %b cyc %0d", period_tick, m_tick(), i); end
            n_cmp++; if (busy !== m_busy()) begin n_bad++; $display("FAIL def_busy got %b exp %b", busy, m_busy()); end
            if (period_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    gap = i - last_tick;
                    n_cmp++; if (gap != DEF) begin n_bad++; $display("FAIL def_tick_spacing got %0d exp %0d", gap, DEF); end
                end
                last_tick = i;
            end
            half();
            n_cmp++; if (clk_out !== m_clk(1)) begin n_bad++; $display("FAIL def_clk_neg got %b exp %b cyc %0d", clk_out, m_clk(1), i); end
        end
    endtask

    // Loads ratio r and runs until it is in force; bounded.
    task automatic set_ratio(input int r);
        cfg_valid = 1'b1; cfg_ratio = W'(r);
        step(); half();
        cfg_valid = 1'b0;
        for (int i = 0; i < 40 && m_pend; i++) begin
            step();
            n_cmp++; if (clk_out !== m_clk(0)) begin n_bad++; $display("FAIL set_clk_pos got %b exp %b", clk_out, m_clk(0)); end
            n_cmp++; if (cfg_ready !== !m_pend) begin n_bad++; $display("FAIL set_ready got %b exp %b", cfg_ready, !m_pend); end
            half();
            n_cmp++; if (clk_out !== m_clk(1)) begin n_bad++; $display("FAIL set_clk_neg got %b exp %b", clk_out, m_clk(1)); end
        end
        n_cmp++; if (m_pend || m_n != r) begin n_bad++; $display("FAIL set_ratio_timeout got n=%0d exp %0d", m_n, r); end
    endtask

    task automatic test_ratio_change();
        set_ratio(4);
        for (int i = 0; i < 20 && !(m_pos == 1); i++) begin step(); half(); end
        cfg_valid = 1'b1; cfg_ratio = 4'd7;
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL chg_ready_low got %b exp 0", cfg_ready); end
        half();
        for (int i = 0; i < 30; i++) begin
            step();
            n_cmp++; if (clk_out !== m_clk(0)) begin n_bad++; $display("FAIL chg_clk_pos got %b exp %b cyc %0d", clk_out, m_clk(0), i); end
            n_cmp++; if (period_tick !== m_tick()) begin n_bad++; $display("FAIL chg_tick got %b exp %b cyc %0d", period_tick, m_tick(), i); end
            n_cmp++; if (cfg_ready !== !m_pend) begin n_bad++; $display("FAIL chg_ready got %b exp %b cyc %0d", cfg_ready, !m_pend, i); end
            half();
            n_cmp++; if (clk_out !== m_clk(1)) begin n_bad++; $display("FAIL chg_clk_neg got %b exp %b cyc %0d", clk_out, m_clk(1), i); end
        end
        n_cmp++; if (m_n != 7) begin n_bad++; $display("FAIL chg_final_n got %0d exp 7", m_n); end
    endtask

    task automatic test_bad_ratio();
        logic [W-1:0] bad [2];
        bad[0] = 4'd1; bad[1] = 4'd0;
        for (int k = 0; k < 2; k++) begin
            cfg_valid = 1'b1; cfg_ratio = bad[k];
            step();
            cfg_valid = 1'b0;
            n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL bad_err_pulse got %b exp 1 ratio %0d", cfg_err, bad[k]); end
            n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL bad_ready got %b exp 1", cfg_ready); end
            n_cmp++; if (clk_out !== m_clk(0)) begin n_bad++; $display("FAIL bad_clk got %b exp %b", clk_out, m_clk(0)); end
            half();
            step();
            n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL bad_err_clear got %b exp 0", cfg_err); end
            n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL bad_ready2 got %b exp 1", cfg_ready); end
            half();
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++; if (period_tick !== m_tick()) begin n_bad++; $display("FAIL bad_tick got %b exp %b", period_tick, m_tick()); end
            half();
            n_cmp++; if (clk_out !== m_clk(1)) begin n_bad++; $display("FAIL bad_clk_neg got %b exp %b", clk_out, m_clk(1)); end
        end
    endtask

    task automatic test_stop_restart();
        set_ratio(6);
        for (int run = 0; run < 2; run++) begin
            for (int i = 0; i < 20 && !(m_pos == 2); i++) begin step(); half(); end
            en = 1'b0;
            for (int i = 0; i < 14; i++) begin
                step();
                n_cmp++; if (busy !== m_busy()) begin n_bad++; $display("FAIL stop_busy got %b exp %b run %0d cyc %0d", busy, m_busy(), run, i); end
                n_cmp++; if (clk_out !== m_clk(0)) begin n_bad++; $display("FAIL stop_clk_pos got %b exp %b run %0d cyc %0d", clk_out, m_clk(0), run, i); end
                n_cmp++; if (period_tick !== m_tick()) begin n_bad++; $display("FAIL stop_tick got %b exp %b", period_tick, m_tick()); end
                half();
                n_cmp++; if (clk_out !== m_clk(1)) begin n_bad++; $display("FAIL stop_clk_neg got %b exp %b", clk_out, m_clk(1)); end
                if (run == 1 && m_pos == 4 && !en) en = 1'b1;
            end
            if (run == 0) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_parked got busy %b exp 0", busy); end
                en = 1'b1;
            end else begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy got %b exp 1", busy); end
            end
        end
    endtask

    task automatic test_hs_on_tick();
        for (int i = 0; i < 20 && !m_tick(); i++) begin step(); half(); end
        n_cmp++; if (period_tick !== 1'b1) begin n_bad++; $display("FAIL hs_tick_seen got %b exp 1", period_tick); end
        cfg_valid = 1'b1; cfg_ratio = 4'd3;
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL hs_ready_low got %b exp 0", cfg_ready); end
        half();
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (clk_out !== m_clk(0)) begin n_bad++; $display("FAIL hs_clk_pos got %b exp %b cyc %0d", clk_out, m_clk(0), i); end
            n_cmp++; if (period_tick !== m_tick()) begin n_bad++; $display("FAIL hs_tick got %b exp %b cyc %0d", period_tick, m_tick(), i); end
            n_cmp++; if (cfg_ready !== !m_pend) begin n_bad++; $display("FAIL hs_ready got %b exp %b cyc %0d", cfg_ready, !m_pend, i); end
            half();
            n_cmp++; if (clk_out !== m_clk(1)) begin n_bad++; $display("FAIL hs_clk_neg got %b exp %b", clk_out, m_clk(1)); end
        end
    endtask

    task automatic test_reset_midperiod();
        int last_tick, gap;
        set_ratio(9);
        for (int i = 0; i < 20 && !(m_pos == 2); i++) begin step(); half(); end
        cfg_valid = 1'b1; cfg_ratio = 4'd2;
        step();
        cfg_valid = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (clk_out !== 1'b0) begin n_bad++; $display("FAIL rmid_clk_out got %b exp 0", clk_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b exp 0", busy); end
        n_cmp++; if (period_tick !== 1'b0) begin n_bad++; $display("FAIL rmid_tick got %b exp 0", period_tick); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got %b exp 1", cfg_ready); end
        half();
        rst = 1'b1;
        last_tick = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (clk_out !== m_clk(0)) begin n_bad++; $display("FAIL rmid_clk_pos got %b exp %b cyc %0d", clk_out, m_clk(0), i); end
            n_cmp++; if (period_tick !== m_tick()) begin n_bad++; $display("FAIL rmid_tick2 got %b exp %b cyc %0d", period_tick, m_tick(), i); end
            if (period_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    gap = i - last_tick;
                    n_cmp++; if (gap != DEF) begin n_bad++; $display("FAIL rmid_spacing got %0d exp %0d", gap, DEF); end
                end
                last_tick = i;
            end
            half();
            n_cmp++; if (clk_out !== m_clk(1)) begin n_bad++; $display("FAIL rmid_clk_neg got %b exp %b", clk_out, m_clk(1)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_ratio = W'($urandom_range(0, 15));
            step();
            n_cmp++; if (clk_out !== m_clk(0)) begin n_bad++; $display("FAIL rnd_clk_pos got %b exp %b cyc %0d", clk_out, m_clk(0), i); end
            n_cmp++; if (period_tick !== m_tick()) begin n_bad++; $display("FAIL rnd_tick got %b exp %b cyc %0d", period_tick, m_tick(), i); end
            n_cmp++; if (busy !== m_busy()) begin n_bad++; $display("FAIL rnd_busy got %b exp %b cyc %0d", busy, m_busy(), i); end
            n_cmp++; if (cfg_ready !== !m_pend) begin n_bad++; $display("FAIL rnd_ready got %b exp %b cyc %0d", cfg_ready, !m_pend, i); end
            n_cmp++; if (cfg_err !== m_err) begin n_bad++; $display("FAIL rnd_err got %b exp %b cyc %0d", cfg_err, m_err, i); end
            half();
            n_cmp++; if (clk_out !== m_clk(1)) begin n_bad++; $display("FAIL rnd_clk_neg got %b exp %b cyc %0d", clk_out, m_clk(1), i); end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_ratio();
        test_ratio_change();
        test_bad_ratio();
        test_stop_restart();
        test_hs_on_tick();
        test_reset_midperiod();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
